// File: rtl/reservation_station_wakeup_if.sv
// Dispatch, result-broadcast and issue signals of the wakeup reservation station.
// Per-source vectors pack src0 in the MSBs; per-bus vectors pack bus 0 in the LSBs.
interface reservation_station_wakeup_if #(
    parameter int NumSrc       = 3,
    parameter int TagWidth     = 6,
    parameter int DataWidth    = 64,
    parameter int PayloadWidth = 84,
    parameter int NumCDB       = 2,
    parameter int RSIdxBits    = 3
);
    logic                          flush;
    logic                          dispValid;
    logic                          dispReady;
    logic [PayloadWidth-1:0]       dispPayload;
    logic [TagWidth-1:0]           dispDestTag;
    logic [NumSrc*TagWidth-1:0]    dispSrcTag;
    logic [NumSrc-1:0]             dispSrcRdy;
    logic [NumSrc*DataWidth-1:0]   dispSrcData;
    logic [NumCDB-1:0]             cdbValid;
    logic [NumCDB*TagWidth-1:0]    cdbTag;
    logic [NumCDB*DataWidth-1:0]   cdbData;
    logic                          issueValid;
    logic                          issueReady;
    logic [PayloadWidth-1:0]       issuePayload;
    logic [TagWidth-1:0]           issueDestTag;
    logic [NumSrc*DataWidth-1:0]   issueSrcData;
    logic [RSIdxBits:0]            occupancy;
    logic                          isFull;

    modport master (
        output flush, dispValid, dispPayload, dispDestTag, dispSrcTag, dispSrcRdy, dispSrcData,
               cdbValid, cdbTag, cdbData, issueReady,
        input  dispReady, issueValid, issuePayload, issueDestTag, issueSrcData, occupancy, isFull
    );

    modport slave (
        input  flush, dispValid, dispPayload, dispDestTag, dispSrcTag, dispSrcRdy, dispSrcData,
               cdbValid, cdbTag, cdbData, issueReady,
        output dispReady, issueValid, issuePayload, issueDestTag, issueSrcData, occupancy, isFull
    );
endinterface

// File: rtl/reservation_station_wakeup.sv
// Reservation station with CDB tag wakeup, age-matrix oldest-ready select and a
// single issue register in front of one functional unit.
module reservation_station_wakeup #(
    parameter int RStationInstance = 0,
    parameter int RSDepth          = 8,
    parameter int RSIdxBits        = 3,
    parameter int NumSrc           = 3,
    parameter int TagWidth         = 6,
    parameter int DataWidth        = 64,
    parameter int PayloadWidth     = 84,
    parameter int NumCDB           = 2
) (
    input logic                         clock_i,
    input logic                         reset_i,
    reservation_station_wakeup_if.slave rsIf
);
    localparam int CntWidth = RSIdxBits + 1;

    if (RStationInstance < 0 || RSDepth > (1 << RSIdxBits)) begin : g_paramCheck
        $error("reservation_station_wakeup: inconsistent parameters");
    end

    logic [RSDepth-1:0]      entValid;
    logic [NumSrc-1:0]       srcRdy    [RSDepth];
    logic [TagWidth-1:0]     srcTag    [RSDepth][NumSrc];
    logic [DataWidth-1:0]    srcData   [RSDepth][NumSrc];
    logic [PayloadWidth-1:0] payload   [RSDepth];
    logic [TagWidth-1:0]     destTag   [RSDepth];
    // olderThan[i][j] set means entry j was already waiting when entry i was allocated
    logic [RSDepth-1:0]      olderThan [RSDepth];
    logic [CntWidth-1:0]     count;

    logic                        issueValidQ;
    logic [PayloadWidth-1:0]     issuePayloadQ;
    logic [TagWidth-1:0]         issueDestTagQ;
    logic [NumSrc*DataWidth-1:0] issueSrcDataQ;

    logic [RSDepth-1:0]   candidate;
    logic [RSIdxBits-1:0] freeIdx, selIdx;
    logic                 freeFound, selFound;
    logic                 isFull, dispFire, loadIssue;
    logic [NumSrc-1:0]    dispRdy;
    logic [TagWidth-1:0]  dispTag  [NumSrc];
    logic [DataWidth-1:0] dispData [NumSrc];

    always_comb begin
        freeIdx   = '0;
        freeFound = 1'b0;
        selIdx    = '0;
        selFound  = 1'b0;
        for (int i = 0; i < RSDepth; i++) begin
            candidate[i] = entValid[i] && (&srcRdy[i]);
        end
        for (int i = 0; i < RSDepth; i++) begin
            if (!entValid[i] && !freeFound) begin
                freeIdx   = RSIdxBits'(i);
                freeFound = 1'b1;
            end
            if (candidate[i] && ((olderThan[i] & candidate) == '0) && !selFound) begin
                selIdx   = RSIdxBits'(i);
                selFound = 1'b1;
            end
        end
    end

    // Descending bus loop so the lowest-index matching bus overrides the others.
    always_comb begin
        for (int s = 0; s < NumSrc; s++) begin
            dispTag[s]  = rsIf.dispSrcTag[(NumSrc-1-s)*TagWidth +: TagWidth];
            dispRdy[s]  = rsIf.dispSrcRdy[NumSrc-1-s];
            dispData[s] = rsIf.dispSrcData[(NumSrc-1-s)*DataWidth +: DataWidth];
            if (!rsIf.dispSrcRdy[NumSrc-1-s]) begin
                for (int b = NumCDB - 1; b >= 0; b--) begin
                    if (rsIf.cdbValid[b] && rsIf.cdbTag[b*TagWidth +: TagWidth] == dispTag[s]) begin
                        dispRdy[s]  = 1'b1;
                        dispData[s] = rsIf.cdbData[b*DataWidth +: DataWidth];
                    end
                end
            end
        end
    end

    assign isFull    = (count == CntWidth'(RSDepth));
    assign dispFire  = rsIf.dispValid && !isFull;
    assign loadIssue = selFound && (!issueValidQ || rsIf.issueReady);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            entValid      <= '0;
            count         <= '0;
            issueValidQ   <= 1'b0;
            issuePayloadQ <= '0;
            issueDestTagQ <= '0;
            issueSrcDataQ <= '0;
            for (int i = 0; i < RSDepth; i++) begin
                srcRdy[i]    <= '0;
                payload[i]   <= '0;
                destTag[i]   <= '0;
                olderThan[i] <= '0;
                for (int s = 0; s < NumSrc; s++) begin
                    srcTag[i][s]  <= '0;
                    srcData[i][s] <= '0;
                end
            end
        end else if (rsIf.flush) begin
            entValid      <= '0;
            count         <= '0;
            issueValidQ   <= 1'b0;
            issuePayloadQ <= '0;
            issueDestTagQ <= '0;
            issueSrcDataQ <= '0;
            for (int i = 0; i < RSDepth; i++) begin
                olderThan[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RSDepth; i++) begin
                for (int s = 0; s < NumSrc; s++) begin
                    if (entValid[i] && !srcRdy[i][s]) begin
                        for (int b = NumCDB - 1; b >= 0; b--) begin
                            if (rsIf.cdbValid[b] && rsIf.cdbTag[b*TagWidth +: TagWidth] == srcTag[i][s]) begin
                                srcRdy[i][s]  <= 1'b1;
                                srcData[i][s] <= rsIf.cdbData[b*DataWidth +: DataWidth];
                            end
                        end
                    end
                end
            end

            // Stale column bits from the slot's previous occupant are cleared on reuse.
            if (dispFire) begin
                entValid[freeIdx] <= 1'b1;
                payload[freeIdx]  <= rsIf.dispPayload;
                destTag[freeIdx]  <= rsIf.dispDestTag;
                for (int s = 0; s < NumSrc; s++) begin
                    srcTag[freeIdx][s]  <= dispTag[s];
                    srcRdy[freeIdx][s]  <= dispRdy[s];
                    srcData[freeIdx][s] <= dispData[s];
                end
                for (int k = 0; k < RSDepth; k++) begin
                    olderThan[k][freeIdx] <= 1'b0;
                end
                olderThan[freeIdx] <= entValid;
            end

            if (loadIssue) begin
                entValid[selIdx] <= 1'b0;
                issueValidQ      <= 1'b1;
                issuePayloadQ    <= payload[selIdx];
                issueDestTagQ    <= destTag[selIdx];
                for (int s = 0; s < NumSrc; s++) begin
                    issueSrcDataQ[(NumSrc-1-s)*DataWidth +: DataWidth] <= srcData[selIdx][s];
                end
            end else if (rsIf.issueReady) begin
                issueValidQ <= 1'b0;
            end

            count <= count + CntWidth'(dispFire) - CntWidth'(loadIssue);
        end
    end

    assign rsIf.dispReady    = !isFull;
    assign rsIf.isFull       = isFull;
    assign rsIf.occupancy    = count;
    assign rsIf.issueValid   = issueValidQ;
    assign rsIf.issuePayload = issuePayloadQ;
    assign rsIf.issueDestTag = issueDestTagQ;
    assign rsIf.issueSrcData = issueSrcDataQ;
endmodule

// File: tb/tb_reservation_station_wakeup.sv
// Directed scenarios plus randomized traffic against an age-ordered queue model.
module tb_reservation_station_wakeup;
    localparam int NS = 3;
    localparam int TW = 6;
    localparam int DW = 64;
    localparam int PW = 84;
    localparam int NC = 2;
    localparam int RD = 8;
    localparam int IB = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reservation_station_wakeup_if #(.NumSrc(NS), .TagWidth(TW), .DataWidth(DW),
        .PayloadWidth(PW), .NumCDB(NC), .RSIdxBits(IB)) rsIf ();

    reservation_station_wakeup #(.RStationInstance(0), .RSDepth(RD), .RSIdxBits(IB), .NumSrc(NS),
        .TagWidth(TW), .DataWidth(DW), .PayloadWidth(PW), .NumCDB(NC)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .rsIf    (rsIf)
    );

    typedef struct {
        logic [PW-1:0]         pay;
        logic [TW-1:0]         dest;
        logic [NS-1:0]         rdy;
        logic [NS-1:0][TW-1:0] tag;
        logic [NS-1:0][DW-1:0] data;
    } ent_t;

    ent_t           mq[$];   // waiting instructions, oldest first
    logic           mIssV;
    logic [PW-1:0]  mPay;
    logic [TW-1:0]  mDest;
    logic [NS*DW-1:0] mData;
    int nAssert = 0;
    int nFail   = 0;

    function automatic int cdbHit(input logic [TW-1:0] t);
        for (int b = 0; b < NC; b++)
            if (rsIf.cdbValid[b] && rsIf.cdbTag[b*TW +: TW] == t) return b;
        return -1;
    endfunction

    task automatic model_clear();
        mq.delete();
        mIssV = 1'b0;
        mPay  = '0;
        mDest = '0;
        mData = '0;
    endtask

    task automatic model_step();
        int sel;
        int b;
        bit load;
        bit canDisp;
        ent_t e;
        if (rsIf.flush) begin
            model_clear();
            return;
        end
        canDisp = mq.size() < RD;
        sel = -1;
        foreach (mq[i]) if (sel < 0 && (&mq[i].rdy)) sel = i;
        load = (sel >= 0) && (!mIssV || rsIf.issueReady);
        foreach (mq[i]) begin
            e = mq[i];
            for (int s = 0; s < NS; s++) begin
                if (!e.rdy[s]) begin
                    b = cdbHit(e.tag[s]);
                    if (b >= 0) begin
                        e.rdy[s]  = 1'b1;
                        e.data[s] = rsIf.cdbData[b*DW +: DW];
                    end
                end
            end
            mq[i] = e;
        end
        if (load) begin
            mIssV = 1'b1;
            mPay  = mq[sel].pay;
            mDest = mq[sel].dest;
            for (int s = 0; s < NS; s++) mData[(NS-1-s)*DW +: DW] = mq[sel].data[s];
            mq.delete(sel);
        end else if (rsIf.issueReady) begin
            mIssV = 1'b0;
        end
        if (rsIf.dispValid && canDisp) begin
            e.pay  = rsIf.dispPayload;
            e.dest = rsIf.dispDestTag;
            for (int s = 0; s < NS; s++) begin
                e.tag[s]  = rsIf.dispSrcTag[(NS-1-s)*TW +: TW];
                e.rdy[s]  = rsIf.dispSrcRdy[NS-1-s];
                e.data[s] = rsIf.dispSrcData[(NS-1-s)*DW +: DW];
                if (!e.rdy[s]) begin
                    b = cdbHit(e.tag[s]);
                    if (b >= 0) begin
                        e.rdy[s]  = 1'b1;
                        e.data[s] = rsIf.cdbData[b*DW +: DW];
                    end
                end
            end
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsIf.flush     = 1'b0;
        rsIf.dispValid = 1'b0;
        rsIf.cdbValid  = '0;
    endtask

    task automatic set_disp(input logic [PW-1:0] pay, input logic [TW-1:0] dest, input logic [NS-1:0] rdy,
                            input logic [NS*TW-1:0] tags, input logic [NS*DW-1:0] data);
        rsIf.dispValid   = 1'b1;
        rsIf.dispPayload = pay;
        rsIf.dispDestTag = dest;
        rsIf.dispSrcRdy  = rdy;
        rsIf.dispSrcTag  = tags;
        rsIf.dispSrcData = data;
    endtask

    task automatic set_cdb(input logic [NC-1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        rsIf.cdbValid = v;
        rsIf.cdbTag   = {t1, t0};
        rsIf.cdbData  = {d1, d0};
    endtask

    task automatic test_reset();
        idle();
        rsIf.issueReady = 1'b0;
        set_disp('0, '0, '0, '0, '0);
        rsIf.dispValid = 1'b0;
        set_cdb('0, '0, '0, '0, '0);
        model_clear();
        rst_n = 1'b0;
        #3;
        nAssert++; if (rsIf.issueValid !== 1'b0) begin nFail++; $display("FAIL reset_issueValid: got %b want 0", rsIf.issueValid); end
        nAssert++; if (rsIf.occupancy !== 4'd0) begin nFail++; $display("FAIL reset_occupancy: got %0d want 0", rsIf.occupancy); end
        nAssert++; if (rsIf.isFull !== 1'b0) begin nFail++; $display("FAIL reset_isFull: got %b want 0", rsIf.isFull); end
        nAssert++; if (rsIf.dispReady !== 1'b1) begin nFail++; $display("FAIL reset_dispReady: got %b want 1", rsIf.dispReady); end
        nAssert++; if ({rsIf.issuePayload, rsIf.issueDestTag, rsIf.issueSrcData} !== '0) begin nFail++; $display("FAIL reset_issueData: got nonzero want 0"); end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        rsIf.issueReady = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_disp(PW'(100 + k), TW'(k), 3'b111, '0, {64'(k), 64'(k + 1), 64'(k + 2)});
            tick();
        end
        nAssert++; if (rsIf.occupancy !== 4'd7) begin nFail++; $display("FAIL fill_occ7: got %0d want 7", rsIf.occupancy); end
        nAssert++; if (rsIf.issuePayload !== PW'(100) || rsIf.issueValid !== 1'b1) begin nFail++; $display("FAIL fill_first: got %0d/%b want 100/1", rsIf.issuePayload, rsIf.issueValid); end
        set_disp(PW'(108), TW'(8), 3'b111, '0, '0);
        tick();
        nAssert++; if (rsIf.occupancy !== 4'd8 || rsIf.isFull !== 1'b1 || rsIf.dispReady !== 1'b0) begin nFail++; $display("FAIL fill_full: got occ %0d full %b rdy %b want 8 1 0", rsIf.occupancy, rsIf.isFull, rsIf.dispReady); end
        set_disp(PW'(109), TW'(9), 3'b111, '0, '0);
        tick();
        nAssert++; if (rsIf.occupancy !== 4'd8) begin nFail++; $display("FAIL fill_ignored: got %0d want 8", rsIf.occupancy); end
        idle();
        rsIf.issueReady = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(100 + k)) begin nFail++; $display("FAIL fill_order: got %0d want %0d", rsIf.issuePayload, 100 + k); end
        end
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b0 || rsIf.occupancy !== 4'd0) begin nFail++; $display("FAIL fill_drained: got v%b occ %0d want 0 0", rsIf.issueValid, rsIf.occupancy); end
    endtask

    task automatic test_wakeup();
        rsIf.issueReady = 1'b1;
        set_disp(PW'(200), TW'(1), 3'b101, {6'd0, 6'd5, 6'd0}, {64'h11, 64'h0, 64'h33});
        tick();
        set_disp(PW'(201), TW'(2), 3'b111, '0, {64'hB0, 64'hB1, 64'hB2});
        tick();
        idle();
        nAssert++; if (rsIf.issueValid !== 1'b0) begin nFail++; $display("FAIL wake_notyet: got %b want 0", rsIf.issueValid); end
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(201)) begin nFail++; $display("FAIL wake_B_first: got %0d want 201", rsIf.issuePayload); end
        set_cdb(2'b01, 6'd5, 6'd0, 64'hDEAD, 64'h0);
        tick();
        idle();
        nAssert++; if (rsIf.issueValid !== 1'b0) begin nFail++; $display("FAIL wake_gap: got %b want 0", rsIf.issueValid); end
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(200)) begin nFail++; $display("FAIL wake_A: got %0d want 200", rsIf.issuePayload); end
        nAssert++; if (rsIf.issueSrcData !== {64'h11, 64'hDEAD, 64'h33}) begin nFail++; $display("FAIL wake_A_data: got %h want 11/DEAD/33", rsIf.issueSrcData); end
        tick();
    endtask

    task automatic test_bypass();
        rsIf.issueReady = 1'b1;
        set_disp(PW'(300), TW'(3), 3'b011, {6'd9, 6'd1, 6'd2}, {64'h0, 64'h22, 64'h33});
        set_cdb(2'b10, 6'd9, 6'd9, 64'hFFFF, 64'h1234);
        tick();
        idle();
        nAssert++; if (rsIf.issueValid !== 1'b0 || rsIf.occupancy !== 4'd1) begin nFail++; $display("FAIL byp_E: got v%b occ %0d want 0 1", rsIf.issueValid, rsIf.occupancy); end
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issueSrcData !== {64'h1234, 64'h22, 64'h33}) begin nFail++; $display("FAIL byp_data: got %h want 1234/22/33", rsIf.issueSrcData); end
        set_disp(PW'(301), TW'(4), 3'b110, {6'd0, 6'd0, 6'd12}, {64'h44, 64'h55, 64'h0});
        tick();
        idle();
        set_cdb(2'b11, 6'd12, 6'd12, 64'hAAAA, 64'hBBBB);
        tick();
        idle();
        tick();
        nAssert++; if (rsIf.issuePayload !== PW'(301) || rsIf.issueSrcData !== {64'h44, 64'h55, 64'hAAAA}) begin nFail++; $display("FAIL cdb_prio: got %h want 44/55/AAAA", rsIf.issueSrcData); end
        tick();
    endtask

    task automatic test_age();
        rsIf.issueReady = 1'b1;
        set_disp(PW'(400), TW'(5), 3'b011, {6'd20, 6'd0, 6'd0}, '0);
        tick();
        set_disp(PW'(401), TW'(6), 3'b011, {6'd30, 6'd0, 6'd0}, '0);
        tick();
        idle();
        set_cdb(2'b01, 6'd20, 6'd0, 64'h1, 64'h0);
        tick();
        idle();
        tick();
        nAssert++; if (rsIf.issuePayload !== PW'(400)) begin nFail++; $display("FAIL age_F: got %0d want 400", rsIf.issuePayload); end
        set_disp(PW'(402), TW'(7), 3'b011, {6'd31, 6'd0, 6'd0}, '0);
        tick();
        idle();
        set_cdb(2'b11, 6'd31, 6'd30, 64'h31, 64'h30);
        tick();
        idle();
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(401)) begin nFail++; $display("FAIL age_X_first: got %0d want 401", rsIf.issuePayload); end
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(402)) begin nFail++; $display("FAIL age_Y_second: got %0d want 402", rsIf.issuePayload); end
        tick();
    endtask

    task automatic test_stall_flush();
        rsIf.issueReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_disp(PW'(500 + k), TW'(k), 3'b111, '0, {64'(k), 64'h7, 64'h8});
            tick();
        end
        idle();
        nAssert++; if (rsIf.occupancy !== 4'd4) begin nFail++; $display("FAIL stall_occ: got %0d want 4", rsIf.occupancy); end
        for (int k = 0; k < 3; k++) begin
            tick();
            nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(500) || rsIf.issueSrcData !== {64'h0, 64'h7, 64'h8}) begin nFail++; $display("FAIL stall_hold: got v%b pay %0d want 1 500", rsIf.issueValid, rsIf.issuePayload); end
        end
        rsIf.flush = 1'b1;
        set_disp(PW'(599), TW'(9), 3'b111, '0, '0);
        set_cdb(2'b01, 6'd1, 6'd0, 64'h5, 64'h0);
        tick();
        idle();
        nAssert++; if (rsIf.issueValid !== 1'b0 || rsIf.occupancy !== 4'd0 || rsIf.dispReady !== 1'b1) begin nFail++; $display("FAIL flush_state: got v%b occ %0d rdy %b want 0 0 1", rsIf.issueValid, rsIf.occupancy, rsIf.dispReady); end
        nAssert++; if (rsIf.issuePayload !== '0 || rsIf.issueSrcData !== '0) begin nFail++; $display("FAIL flush_data: got nonzero want 0"); end
        tick();
        nAssert++; if (rsIf.occupancy !== 4'd0 || rsIf.issueValid !== 1'b0) begin nFail++; $display("FAIL flush_discard: got occ %0d want 0", rsIf.occupancy); end
    endtask

    task automatic test_reset_mid();
        rsIf.issueReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_disp(PW'(700 + k), TW'(k), 3'b011, {6'd40, 6'd0, 6'd0}, '0);
            tick();
        end
        idle();
        nAssert++; if (rsIf.occupancy !== 4'd5) begin nFail++; $display("FAIL rstmid_occ5: got %0d want 5", rsIf.occupancy); end
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        nAssert++; if (rsIf.occupancy !== 4'd0 || rsIf.dispReady !== 1'b1 || rsIf.issueValid !== 1'b0 || rsIf.isFull !== 1'b0) begin nFail++; $display("FAIL rstmid_async: got occ %0d rdy %b v %b want 0 1 0", rsIf.occupancy, rsIf.dispReady, rsIf.issueValid); end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsIf.issueReady = 1'b1;
        set_disp(PW'(600), TW'(1), 3'b111, '0, {64'h6, 64'h7, 64'h8});
        tick();
        idle();
        nAssert++; if (rsIf.occupancy !== 4'd1) begin nFail++; $display("FAIL rstmid_disp: got %0d want 1", rsIf.occupancy); end
        tick();
        nAssert++; if (rsIf.issueValid !== 1'b1 || rsIf.issuePayload !== PW'(600)) begin nFail++; $display("FAIL rstmid_issue: got %0d want 600", rsIf.issuePayload); end
        tick();
    endtask

    task automatic test_random();
        logic [NS*TW-1:0] tags;
        for (int c = 0; c < 600; c++) begin
            idle();
            rsIf.flush      = ($urandom_range(0, 59) == 0);
            rsIf.issueReady = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6) begin
                for (int s = 0; s < NS; s++) tags[s*TW +: TW] = TW'($urandom_range(0, 7));
                set_disp(PW'({$urandom, $urandom, $urandom}), TW'($urandom), NS'($urandom),
                         tags, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            end
            set_cdb(NC'($urandom), TW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)),
                    {$urandom, $urandom}, {$urandom, $urandom});
            tick();
            nAssert++; if (rsIf.issueValid !== mIssV) begin nFail++; $display("FAIL rnd_issueValid c%0d: got %b want %b", c, rsIf.issueValid, mIssV); end
            nAssert++; if (rsIf.occupancy !== (IB+1)'(mq.size())) begin nFail++; $display("FAIL rnd_occupancy c%0d: got %0d want %0d", c, rsIf.occupancy, mq.size()); end
            nAssert++; if (rsIf.isFull !== (mq.size() == RD) || rsIf.dispReady !== (mq.size() < RD)) begin nFail++; $display("FAIL rnd_full c%0d: got full %b rdy %b want size %0d", c, rsIf.isFull, rsIf.dispReady, mq.size()); end
            nAssert++; if ({rsIf.issuePayload, rsIf.issueDestTag} !== {mPay, mDest}) begin nFail++; $display("FAIL rnd_payload c%0d: got %h want %h", c, rsIf.issuePayload, mPay); end
            nAssert++; if (rsIf.issueSrcData !== mData) begin nFail++; $display("FAIL rnd_srcData c%0d: got %h want %h", c, rsIf.issueSrcData, mData); end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_wakeup();
        test_bypass();
        test_age();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
